// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words from a FIFO read port and emits them as a
// packetised valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  read_req,
    input  logic                  data_in_vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           pkt_cnt,
    output logic                  busy,
    output logic                  ovf_err
);

    localparam int WW = $clog2(PKT_LEN);
    localparam logic [WW-1:0] LAST = WW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            occ;
    logic [1:0]            occ_mid;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;
    logic [WW-1:0]         wcnt;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [2:0]            credit_used;
    logic [2:0]            credit_max;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)
                    state_d = RUN;
                else if (occ == 2'd0 && !inflight)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_valid = rst & (occ != 2'd0);
    assign m_data  = m_valid ? ent0 : '0;
    assign m_last  = m_valid & (wcnt == LAST);
    assign busy    = rst & (state_q != IDLE);
    assign pop     = m_valid & m_ready;

    // A word leaving this cycle frees its slot, keeping reads back to back.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign credit_max  = 3'd2 + {2'b00, pop};
    assign read_req    = rst & (state_q == RUN) & ~fifo_empty
                       & (credit_used < credit_max);

    assign push_ok = data_in_vld & inflight & ((occ != 2'd2) | pop);
    assign drop    = data_in_vld & ~push_ok;
    assign occ_mid = occ - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            ent0     <= '0;
            ent1     <= '0;
            wcnt     <= '0;
            pkt_cnt  <= 16'd0;
            ovf_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= read_req | (inflight & ~data_in_vld);
            if (pop)
                ent0 <= ent1;
            // Push lands behind whatever remains after this cycle's pop.
            if (push_ok) begin
                if (occ_mid == 2'd0)
                    ent0 <= data_in;
                else
                    ent1 <= data_in;
            end
            occ <= occ_mid + {1'b0, push_ok};
            if (pop) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
                if (m_last)
                    pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (drop)
                ovf_err <= 1'b1;
        end
    end

endmodule
